// File: rtl/dff_tester_pkg.sv
// dff_tester_pkg: states, step encoding and the fixed stimulus table for the DFF tester.
package dff_tester_pkg;
   typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
   typedef struct packed {
      logic rst;
      logic ce;
      logic d;
      logic oe;
   } step_t;
   localparam int NUM_STEPS = 8;
   localparam step_t STEPS [NUM_STEPS] = '{
      step_t'(4'b1001), step_t'(4'b0111), step_t'(4'b0001), step_t'(4'b0101),
      step_t'(4'b0010), step_t'(4'b0111), step_t'(4'b1101), step_t'(4'b0111)
   };
   // m is {m4,m3,m2,m1}; q1 and q3 are inverted outputs of the DUT
   function automatic logic [3:0] exp_pins(input logic [3:0] m, input logic oe, input logic hiz);
      return oe ? {m[3], ~m[2], m[1], ~m[0]} : {4{hiz}};
   endfunction
endpackage

// File: rtl/dff_tester_sync.sv
// dff_tester_sync: 2-flop synchronizer for the asynchronous DUT output pins.
module dff_tester_sync (
   input  logic       clk,
   input  logic       rstin_n,
   input  logic [3:0] d,
   output logic [3:0] q
);
   logic [3:0] s1;
   always_ff @(posedge clk or negedge rstin_n)
      if (!rstin_n) {q, s1} <= 8'h00;
      else          {q, s1} <= {s1, d};
endmodule

// File: rtl/dff_tester.sv
// dff_tester: drives an external DFF through a fixed 8-step sequence and checks its pins.
module dff_tester
   import dff_tester_pkg::*;
#(
   parameter int   SETTLE  = 4,
   parameter logic HIZ_VAL = 1'b1
) (
   input  logic       clk,
   input  logic       rstin_n,
   input  logic       start,
   input  logic [3:0] dut_q,
   output logic       dut_d,
   output logic       dut_rst,
   output logic       dut_ce,
   output logic       dut_oe,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic       fail_valid,
   output logic [2:0] fail_step,
   output logic [3:0] fail_bits
);
   state_t     state_r, state_n;
   logic [3:0] cnt, m, q_s, diff;
   logic [2:0] step, step_n;

   dff_tester_sync u_sync (.clk(clk), .rstin_n(rstin_n), .d(dut_q), .q(q_s));

   always_ff @(posedge clk or negedge rstin_n)
      if (!rstin_n) state_r <= IDLE;
      else          state_r <= state_n;

   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE, DONE: state_n = start ? DRIVE : state_r;
         DRIVE:      state_n = WAIT;
         WAIT:       state_n = (cnt == 4'(SETTLE - 1)) ? CHECK : WAIT;
         CHECK:      state_n = (step == 3'(NUM_STEPS - 1)) ? DONE : DRIVE;
         default:    state_n = IDLE;
      endcase
   end

   always_comb begin
      busy = state_r inside {DRIVE, WAIT, CHECK};
      done = state_r == DONE;
      pass = done && err_count == 8'd0;
   end

   assign step_n = (state_r == CHECK) ? step + 3'd1 : 3'd0;
   assign diff   = exp_pins(m, dut_oe, HIZ_VAL) ^ q_s;

   // the reference model captures with the DUT, on the edge that ends DRIVE
   always_ff @(posedge clk or negedge rstin_n)
      if (!rstin_n) begin
         cnt        <= 4'd0;
         step       <= 3'd0;
         {dut_rst, dut_ce, dut_d, dut_oe} <= 4'b1000;
         m          <= 4'b1001;
         err_count  <= 8'd0;
         fail_valid <= 1'b0;
         fail_step  <= 3'd0;
         fail_bits  <= 4'd0;
      end else begin
         cnt <= (state_r == WAIT) ? cnt + 4'd1 : 4'd0;
         if (state_n == DRIVE) begin
            step <= step_n;
            {dut_rst, dut_ce, dut_d, dut_oe} <= STEPS[step_n];
         end
         if (state_r == DRIVE) m <= dut_rst ? 4'b1001 : dut_ce ? {4{dut_d}} : m;
         if (state_n == DRIVE && state_r != CHECK) begin
            err_count  <= 8'd0;
            fail_valid <= 1'b0;
            fail_step  <= 3'd0;
            fail_bits  <= 4'd0;
         end else if (state_r == CHECK && |diff) begin
            err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
            if (!fail_valid) begin
               fail_valid <= 1'b1;
               fail_step  <= step;
               fail_bits  <= diff;
            end
         end
      end
endmodule

// File: tb/tb_dff_tester.sv
// tb_dff_tester: faulty-DFF board model around dff_tester, checked against a per-step run model.
module tb_dff_tester;
   localparam int SETTLE = 4;
   localparam int LAT    = 8 * (SETTLE + 2) + 1;
   localparam logic [3:0] TBL [8] = '{4'b1001, 4'b0111, 4'b0001, 4'b0101,
                                      4'b0010, 4'b0111, 4'b1101, 4'b0111};
   localparam logic [3:0] EXP [8] = '{4'b1100, 4'b1010, 4'b1010, 4'b0101,
                                      4'b1111, 4'b1010, 4'b1100, 4'b1010};

   logic       clk = 1'b0, rstin_n = 1'b0, start = 1'b0;
   logic [3:0] dut_q;
   logic       dut_d, dut_rst, dut_ce, dut_oe, busy, done, pass, fail_valid;
   logic [7:0] err_count;
   logic [2:0] fail_step;
   logic [3:0] fail_bits;
   int         errors = 0, checks = 0;

   logic [3:0] fm = 4'h0, fv = 4'h0, dm, drv, pin;
   logic       fi = 1'b0, fn = 1'b0;
   logic [7:0] force_val;

   dff_tester #(.SETTLE(SETTLE), .HIZ_VAL(1'b1)) dut (
      .clk(clk), .rstin_n(rstin_n), .start(start), .dut_q(dut_q),
      .dut_d(dut_d), .dut_rst(dut_rst), .dut_ce(dut_ce), .dut_oe(dut_oe),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_valid(fail_valid), .fail_step(fail_step), .fail_bits(fail_bits)
   );

   always #5 clk = ~clk;

   // board: DFF with stuck driver bits (fm/fv), optional oe ignore (fi), pin inversion (fn), pull-ups
   always @(posedge clk)
      if (dut_rst)     dm <= 4'b1001;
      else if (dut_ce) dm <= {4{dut_d}};
   always_comb begin
      drv   = {dm[3], ~dm[2], dm[1], ~dm[0]};
      drv   = (drv & ~fm) | (fv & fm);
      pin   = (dut_oe || fi) ? drv : 4'hF;
      dut_q = fn ? ~pin : pin;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic void ref_run(input logic [3:0] f_m, input logic [3:0] f_v, input logic f_i,
                                   input logic f_n, output int n, output int fs, output logic [3:0] fb);
      logic [3:0] m, a, t;
      m = 4'b1001; n = 0; fs = 0; fb = 4'h0;
      for (int s = 0; s < 8; s++) begin
         t = TBL[s];
         if (t[3])      m = 4'b1001;
         else if (t[2]) m = {4{t[1]}};
         a = {m[3], ~m[2], m[1], ~m[0]};
         a = (a & ~f_m) | (f_v & f_m);
         if (!(t[0] || f_i)) a = 4'hF;
         if (f_n) a = ~a;
         if (a !== EXP[s]) begin
            if (n == 0) begin fs = s; fb = a ^ EXP[s]; end
            n++;
         end
      end
   endfunction

   // pre >= 0 preloads err_count early in the run to reach saturation quickly
   task automatic run(input logic [3:0] f_m, input logic [3:0] f_v, input logic f_i,
                      input logic f_n, input int pre);
      int n, fs, cyc, b1, b2, n_exp;
      logic [3:0] fb;
      fm = f_m; fv = f_v; fi = f_i; fn = f_n;
      ref_run(f_m, f_v, f_i, f_n, n, fs, fb);
      n_exp = (pre >= 0) ? ((pre + n > 255) ? 255 : pre + n) : n;
      b1 = $urandom_range(2, LAT - 2);
      b2 = $urandom_range(2, LAT - 2);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 1;
      chk("restart_done_clear", done, 0);
      chk("restart_busy", busy, 1);
      chk("restart_err_clear", err_count, 0);
      chk("restart_fail_clear", fail_valid, 0);
      while (!done && cyc < 4 * LAT) begin
         start = (cyc == b1 || cyc == b2);
         if (pre >= 0 && cyc == 2) begin
            force_val = 8'(pre);
            force dut.err_count = force_val;
         end
         if (pre >= 0 && cyc == 3) release dut.err_count;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("latency", cyc, LAT);
      chk("done", done, 1);
      chk("busy_end", busy, 0);
      chk("err_count", err_count, n_exp);
      chk("pass", pass, n_exp == 0);
      chk("fail_valid", fail_valid, n > 0);
      chk("fail_step", fail_step, (n > 0) ? fs : 0);
      chk("fail_bits", fail_bits, (n > 0) ? fb : 4'h0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_dut_rst", dut_rst, 1);
      chk("rst_dut_ce", dut_ce, 0);
      chk("rst_dut_d", dut_d, 0);
      chk("rst_dut_oe", dut_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_fail", {fail_valid, fail_step, fail_bits}, 0);
      rstin_n = 1'b1;
      repeat (2) @(negedge clk);
      run(4'h0, 4'h0, 1'b0, 1'b0, -1);
      run(4'b0100, 4'h0, 1'b0, 1'b0, -1);
      run(4'h0, 4'h0, 1'b1, 1'b0, -1);
      run(4'h0, 4'h0, 1'b0, 1'b0, -1);
      // abort in the WAIT phase of step 3
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (2 + 3 * (SETTLE + 2)) @(negedge clk);
      chk("abort_busy_before", busy, 1);
      #2 rstin_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_dut_rst", dut_rst, 1);
      chk("abort_dut_oe", dut_oe, 0);
      chk("abort_done", done, 0);
      @(negedge clk) rstin_n = 1'b1;
      run(4'h0, 4'h0, 1'b0, 1'b0, -1);
      for (int i = 0; i < 6; i++)
         run(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      run(4'h0, 4'h0, 1'b0, 1'b1, 250);
      run(4'h0, 4'h0, 1'b0, 1'b0, -1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
